// File: rtl/div_seq_if.sv
// div_seq_if: launch/result bundle between the controller and the
// sequential divider. The controller (master) drives the operands and the
// start request. The divider (slave) returns the handshake, the result
// registers and the status flags.
interface div_seq_if #(
    parameter int W = 8
);
    logic         start;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;

    modport master (
        output start, sgn, a, b,
        input  busy, done, q, r, dz, ovf
    );

    modport slave (
        input  start, sgn, a, b,
        output busy, done, q, r, dz, ovf
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider that resolves one quotient bit per
// clock. It supports signed (two's complement) and unsigned operands, and
// flags divide-by-zero and signed overflow.
//
// The dividend-magnitude shift register doubles as the quotient register.
// Each step shifts the next dividend bit out of its top and shifts the new
// quotient bit into its bottom. After W steps it holds |q|.
//
// The CALC state ends with one extra cycle in which the counter is zero.
// That cycle applies the sign correction and loads the result registers.
// A divide by zero uses only this cycle, so its result lands one edge after
// launch.
module div_seq #(
    parameter int W = 8
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t        state;
    state_t        state_nx;

    logic [CW-1:0] cnt;
    logic [W-1:0]  rem;
    logic [W-1:0]  dvd;
    logic [W-1:0]  bmag;
    logic [W-1:0]  a_hold;
    logic          neg_q;
    logic          neg_r;
    logic          dz_pend;
    logic          ovf_pend;

    logic [W-1:0]  q_reg;
    logic [W-1:0]  r_reg;
    logic          dz_reg;
    logic          ovf_reg;

    logic          accept;
    logic          a_neg_in;
    logic          b_neg_in;
    logic [W-1:0]  a_mag_in;
    logic [W-1:0]  b_mag_in;
    logic [W:0]    part;
    logic [W:0]    part_sub;
    logic          ge;
    logic [W-1:0]  q_fin;
    logic [W-1:0]  r_fin;

    assign accept   = bus.start && ((state == IDLE) || (state == FIN));
    assign a_neg_in = bus.sgn & bus.a[W-1];
    assign b_neg_in = bus.sgn & bus.b[W-1];
    assign a_mag_in = a_neg_in ? -bus.a : bus.a;
    assign b_mag_in = b_neg_in ? -bus.b : bus.b;

    // The partial remainder is one bit wider than the operands, so the
    // compare and subtract against |b| can never wrap.
    assign part     = {rem, dvd[W-1]};
    assign part_sub = part - {1'b0, bmag};
    assign ge       = (part >= {1'b0, bmag});

    assign q_fin    = neg_q ? -dvd : dvd;
    assign r_fin    = neg_r ? -rem : rem;

    // State register; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; FIN accepts a new start exactly like IDLE does.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                state_nx = bus.start ? CALC : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture, per-cycle restoring step, and result loading.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            bmag     <= '0;
            a_hold   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_pend  <= 1'b0;
            ovf_pend <= 1'b0;
            q_reg    <= '0;
            r_reg    <= '0;
            dz_reg   <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (accept) begin
            cnt      <= (bus.b == '0) ? '0 : CW'(W);
            rem      <= '0;
            dvd      <= a_mag_in;
            bmag     <= b_mag_in;
            a_hold   <= bus.a;
            neg_q    <= a_neg_in ^ b_neg_in;
            neg_r    <= a_neg_in;
            dz_pend  <= (bus.b == '0);
            ovf_pend <= bus.sgn && (bus.a == {1'b1, {(W-1){1'b0}}}) && (bus.b == '1);
        end else if (state == CALC) begin
            if (cnt != '0) begin
                rem <= ge ? part_sub[W-1:0] : part[W-1:0];
                dvd <= {dvd[W-2:0], ge};
                cnt <= cnt - CW'(1);
            end else if (dz_pend) begin
                q_reg   <= '1;
                r_reg   <= a_hold;
                dz_reg  <= 1'b1;
                ovf_reg <= 1'b0;
            end else begin
                q_reg   <= q_fin;
                r_reg   <= r_fin;
                dz_reg  <= 1'b0;
                ovf_reg <= ovf_pend;
            end
        end
    end

    assign bus.busy = (state == CALC);
    assign bus.done = (state == FIN);
    assign bus.q    = q_reg;
    assign bus.r    = r_reg;
    assign bus.dz   = dz_reg;
    assign bus.ovf  = ovf_reg;
endmodule
